// File: rtl/prog_loader_ram_pkg.sv
// Shared loader definitions: state encodings, state width and default widths.
// Optional build macro LOAD_CHECKSUM_EN is consumed by prog_loader_ram.sv.
`ifndef PROG_LOADER_RAM_DEFS
`define PROG_LOADER_RAM_DEFS
`define LDR_STATE_W   2
`define LDR_CLEAR     2'd0
`define LDR_LOAD      2'd1
`define LDR_RUN       2'd2
`define LDR_ERROR     2'd3
`define PLR_DATALINES 16
`define PLR_ADLINES   8
`endif

package prog_loader_ram_pkg;
    localparam int LDR_STATE_W   = `LDR_STATE_W;
    localparam int DATALINES_DEF = `PLR_DATALINES;
    localparam int ADLINES_DEF   = `PLR_ADLINES;

    typedef enum logic [LDR_STATE_W-1:0] {
        ST_CLEAR = `LDR_CLEAR,
        ST_LOAD  = `LDR_LOAD,
        ST_RUN   = `LDR_RUN,
        ST_ERROR = `LDR_ERROR
    } ldr_state_t;
endpackage

// File: rtl/prog_loader_ram_mem_array.sv
// DEPTH x datalines storage: one synchronous write port, one asynchronous read port.
module prog_loader_ram_mem_array #(
    parameter int datalines = 16,
    parameter int adlines   = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [adlines-1:0]   waddr,
    input  logic [datalines-1:0] wdata,
    input  logic [adlines-1:0]   raddr,
    output logic [datalines-1:0] rdata
);
    logic [datalines-1:0] mem [2**adlines];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/prog_loader_ram.sv
// Program/data RAM that self-clears, loads an image from address 1, then serves the CPU.
// Build option: define LOAD_CHECKSUM_EN to treat the last word as an XOR checksum.
module prog_loader_ram
    import prog_loader_ram_pkg::*;
#(
    parameter int datalines = DATALINES_DEF,
    parameter int adlines   = ADLINES_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [adlines-1:0]   addressbus,
    input  logic                 read,
    input  logic                 write,
    input  logic [datalines-1:0] toram,
    output logic [datalines-1:0] fromram,
    output logic                 cpu_enable,
    input  logic [datalines-1:0] load_data,
    input  logic                 load_valid,
    input  logic                 load_last,
    output logic                 load_ready,
    output logic [adlines-1:0]   load_count,
    output logic                 load_error,
    output logic                 busy
);
    localparam logic [adlines-1:0] LAST_ADDR = {adlines{1'b1}};

    ldr_state_t state, state_nx;
    logic [adlines-1:0]   clr_ptr, wr_ptr, count_q;
    logic                 err_q;
    logic                 accept, overflow, ld_wr, ld_done, ld_fail;
    logic                 we;
    logic [adlines-1:0]   waddr;
    logic [datalines-1:0] wdata, rdata;

    assign accept   = (state == ST_LOAD) && load_valid;
    assign overflow = accept && !load_last && (wr_ptr == LAST_ADDR);

`ifdef LOAD_CHECKSUM_EN
    logic [datalines-1:0] csum;
    // The checksum word itself never reaches memory.
    assign ld_wr   = accept && !load_last;
    assign ld_done = accept && load_last && (csum == load_data);
    assign ld_fail = overflow || (accept && load_last && (csum != load_data));
`else
    assign ld_wr   = accept;
    assign ld_done = accept && load_last;
    assign ld_fail = overflow;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= ST_CLEAR;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        we         = 1'b0;
        waddr      = '0;
        wdata      = '0;
        load_ready = 1'b0;
        busy       = 1'b0;
        cpu_enable = 1'b0;
        case (state)
            ST_CLEAR: begin
                busy  = 1'b1;
                we    = 1'b1;
                waddr = clr_ptr;
                if (clr_ptr == LAST_ADDR) state_nx = ST_LOAD;
            end
            ST_LOAD: begin
                busy       = 1'b1;
                load_ready = 1'b1;
                we         = ld_wr;
                waddr      = wr_ptr;
                wdata      = load_data;
                if (ld_done)      state_nx = ST_RUN;
                else if (ld_fail) state_nx = ST_ERROR;
            end
            ST_RUN: begin
                cpu_enable = 1'b1;
                we         = write;
                waddr      = addressbus;
                wdata      = toram;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_ptr <= '0;
            wr_ptr  <= adlines'(1);
            count_q <= '0;
            err_q   <= 1'b0;
`ifdef LOAD_CHECKSUM_EN
            csum    <= '0;
`endif
        end else begin
            if (state == ST_CLEAR) clr_ptr <= clr_ptr + 1'b1;
            if (ld_wr) begin
                if (wr_ptr != LAST_ADDR)  wr_ptr  <= wr_ptr + 1'b1;
                if (count_q != LAST_ADDR) count_q <= count_q + 1'b1;
`ifdef LOAD_CHECKSUM_EN
                csum <= csum ^ load_data;
`endif
            end
            if (ld_fail) err_q <= 1'b1;
        end
    end

    prog_loader_ram_mem_array #(.datalines(datalines), .adlines(adlines)) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (addressbus),
        .rdata (rdata)
    );

    // Combinational read: the CPU samples one edge after driving the address.
    assign fromram    = (state == ST_RUN && read) ? rdata : '0;
    assign load_count = count_q;
    assign load_error = err_q;
endmodule
